// File: rtl/arb_out_buffer_pkg.sv
// Shared constants and helpers for the arbiter output buffer.
package arb_out_buffer_pkg;

    localparam int DATA_W = 32;
    localparam int LOST_W = 16;
    localparam logic [LOST_W-1:0] LOST_SAT = 16'hFFFF;

    // True when an occupancy value has reached the given level.
    function automatic logic occ_at_least(input logic [31:0] occ, input logic [31:0] level);
        return (occ >= level);
    endfunction

endpackage

// File: rtl/arb_out_buffer_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port on one clock.
// The read data register has no reset so the array maps onto block RAM.
module arb_out_buffer_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          BUS_CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rd_data_r;

    // Write port
    always_ff @(posedge BUS_CLK) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the data holds until the next read
    always_ff @(posedge BUS_CLK) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/arb_out_buffer.sv
// Output buffer between the round-robin arbiter and the transfer interface.
// Words enter under READY/WRITE, are stored in a RAM FIFO and leave
// first-word-fall-through under VALID/READ. The RAM read register acts as the
// one-entry output register; a word read from RAM no longer counts as occupancy.
module arb_out_buffer
    import arb_out_buffer_pkg::*;
#(
    parameter int DEPTH               = 1024,
    parameter int AW                  = $clog2(DEPTH),
    parameter int NEAR_FULL_THRESHOLD = 960
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              ARB_WRITE_OUT,
    input  logic [31:0]       ARB_DATA_OUT,
    output logic              ARB_READY_OUT,
    output logic [31:0]       OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READ,
    input  logic              CLEAR,
    output logic              FIFO_FULL,
    output logic              FIFO_NEAR_FULL,
    output logic [AW:0]       FILL_LEVEL,
    output logic [31:0]       WORD_COUNT,
    output logic [15:0]       LOST_COUNT
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);

    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         occ_r;
    logic [AW:0]         occ_next_s;
    logic                out_valid_r;
    logic                out_valid_next_s;
    logic                accept_d_r;
    logic                ready_r;
    logic                full_r;
    logic                near_full_r;
    logic [31:0]         word_count_r;
    logic [LOST_W-1:0]   lost_count_r;
    logic [DATA_W-1:0]   ram_rdata_s;
    logic                accept_s;
    logic                drop_s;
    logic                pop_s;
    logic                ram_avail_s;
    logic                prefetch_s;

    assign accept_s = ARB_WRITE_OUT && ready_r && !CLEAR;
    assign drop_s   = ARB_WRITE_OUT && !ready_r && !CLEAR;
    assign pop_s    = OUT_READ && out_valid_r;
    // A word written on the previous edge is not read back yet, which gives
    // the empty buffer its two-edge write-to-valid latency.
    assign ram_avail_s = (occ_r > {{AW{1'b0}}, accept_d_r});
    assign prefetch_s  = (!out_valid_r || pop_s) && ram_avail_s && !CLEAR;

    arb_out_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .BUS_CLK (BUS_CLK),
        .wr_en   (accept_s),
        .wr_addr (wr_ptr_r),
        .wr_data (ARB_DATA_OUT),
        .rd_en   (prefetch_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_rdata_s)
    );

    // Next occupancy from this cycle's accept and prefetch
    always_comb begin
        occ_next_s = occ_r;
        if (CLEAR) begin
            occ_next_s = {(AW + 1){1'b0}};
        end else begin
            case ({accept_s, prefetch_s})
                2'b10:   occ_next_s = occ_r + OCC_ONE;
                2'b01:   occ_next_s = occ_r - OCC_ONE;
                default: occ_next_s = occ_r;
            endcase
        end
    end

    // Output stage fill: a prefetch refills it, a pop without refill empties it
    always_comb begin
        out_valid_next_s = out_valid_r;
        if (prefetch_s) begin
            out_valid_next_s = 1'b1;
        end else if (pop_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end

    // Pointers, occupancy and output-stage valid
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            occ_r       <= {(AW + 1){1'b0}};
            out_valid_r <= 1'b0;
            accept_d_r  <= 1'b0;
        end else if (CLEAR) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            occ_r       <= {(AW + 1){1'b0}};
            out_valid_r <= 1'b0;
            accept_d_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (prefetch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r       <= occ_next_s;
            out_valid_r <= out_valid_next_s;
            accept_d_r  <= accept_s;
        end
    end

    // Status flags registered from the next occupancy
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            ready_r     <= 1'b0;
            full_r      <= 1'b0;
            near_full_r <= 1'b0;
        end else begin
            ready_r     <= !occ_at_least(32'(occ_next_s), 32'(DEPTH));
            full_r      <= occ_at_least(32'(occ_next_s), 32'(DEPTH));
            near_full_r <= occ_at_least(32'(occ_next_s), 32'(NEAR_FULL_THRESHOLD));
        end
    end

    // Accepted-word counter (wraps) and lost-word counter (saturates)
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            word_count_r <= 32'd0;
            lost_count_r <= {LOST_W{1'b0}};
        end else if (CLEAR) begin
            word_count_r <= 32'd0;
            lost_count_r <= {LOST_W{1'b0}};
        end else begin
            if (accept_s) begin
                word_count_r <= word_count_r + 32'd1;
            end
            if (drop_s && (lost_count_r != LOST_SAT)) begin
                lost_count_r <= lost_count_r + 16'd1;
            end
        end
    end

    assign ARB_READY_OUT  = ready_r;
    assign OUT_VALID      = out_valid_r;
    assign OUT_DATA       = out_valid_r ? ram_rdata_s : {DATA_W{1'b0}};
    assign FIFO_FULL      = full_r;
    assign FIFO_NEAR_FULL = near_full_r;
    assign FILL_LEVEL     = occ_r;
    assign WORD_COUNT     = word_count_r;
    assign LOST_COUNT     = lost_count_r;

endmodule

// File: tb/tb_arb_out_buffer.sv
// Directed self-checking bench for arb_out_buffer with DEPTH=16, threshold 12.
module tb_arb_out_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int THR   = 12;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        ARB_WRITE_OUT;
    logic [31:0] ARB_DATA_OUT;
    logic        ARB_READY_OUT;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READ;
    logic        CLEAR;
    logic        FIFO_FULL;
    logic        FIFO_NEAR_FULL;
    logic [AW:0] FILL_LEVEL;
    logic [31:0] WORD_COUNT;
    logic [15:0] LOST_COUNT;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] seq;
    int fill_exp;

    arb_out_buffer #(
        .DEPTH               (DEPTH),
        .AW                  (AW),
        .NEAR_FULL_THRESHOLD (THR)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .ARB_WRITE_OUT  (ARB_WRITE_OUT),
        .ARB_DATA_OUT   (ARB_DATA_OUT),
        .ARB_READY_OUT  (ARB_READY_OUT),
        .OUT_DATA       (OUT_DATA),
        .OUT_VALID      (OUT_VALID),
        .OUT_READ       (OUT_READ),
        .CLEAR          (CLEAR),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
        .FILL_LEVEL     (FILL_LEVEL),
        .WORD_COUNT     (WORD_COUNT),
        .LOST_COUNT     (LOST_COUNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        BUS_RST       = 1'b1;
        ARB_WRITE_OUT = 1'b0;
        ARB_DATA_OUT  = 32'd0;
        OUT_READ      = 1'b0;
        CLEAR         = 1'b0;
        step();
        step();

        // Reset state
        chk1 ("rst_ready", ARB_READY_OUT, 1'b0);
        chk1 ("rst_valid", OUT_VALID, 1'b0);
        chk32("rst_data", OUT_DATA, 32'd0);
        chk32("rst_fill", 32'(FILL_LEVEL), 32'd0);
        chk32("rst_words", WORD_COUNT, 32'd0);
        chk32("rst_lost", 32'(LOST_COUNT), 32'd0);
        chk1 ("rst_full", FIFO_FULL, 1'b0);
        chk1 ("rst_nfull", FIFO_NEAR_FULL, 1'b0);
        BUS_RST = 1'b0;
        step();
        chk1("ready_after_rst", ARB_READY_OUT, 1'b1);

        // Single write, two edges to valid
        ARB_WRITE_OUT = 1'b1;
        ARB_DATA_OUT  = 32'hA5A5_0001;
        step();
        ARB_WRITE_OUT = 1'b0;
        chk1 ("single_valid_e0", OUT_VALID, 1'b0);
        chk32("single_fill_e0", 32'(FILL_LEVEL), 32'd1);
        step();
        chk1 ("single_valid_e1", OUT_VALID, 1'b0);
        step();
        chk1 ("single_valid_e2", OUT_VALID, 1'b1);
        chk32("single_data", OUT_DATA, 32'hA5A5_0001);
        chk32("single_words", WORD_COUNT, 32'd1);
        chk32("single_fill", 32'(FILL_LEVEL), 32'd0);
        OUT_READ = 1'b1;
        step();
        OUT_READ = 1'b0;
        chk1("single_popped", OUT_VALID, 1'b0);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        chk32("clear_words", WORD_COUNT, 32'd0);

        // 17 back-to-back writes, no reads
        for (int i = 0; i < 17; i++) begin
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = 32'h1000_0000 + 32'(i);
            chk1("fill_ready", ARB_READY_OUT, 1'b1);
            exp_q.push_back(ARB_DATA_OUT);
            step();
            fill_exp = (i < 2) ? (i + 1) : i;
            chk32("fill_level", 32'(FILL_LEVEL), 32'(fill_exp));
            chk1 ("fill_nfull", FIFO_NEAR_FULL, (fill_exp >= THR) ? 1'b1 : 1'b0);
            chk1 ("fill_full", FIFO_FULL, (fill_exp == DEPTH) ? 1'b1 : 1'b0);
        end
        chk1 ("full_ready", ARB_READY_OUT, 1'b0);
        chk1 ("full_valid", OUT_VALID, 1'b1);
        ARB_DATA_OUT = 32'hBAD0_BAD0;
        repeat (3) step();
        ARB_WRITE_OUT = 1'b0;
        chk32("full_lost", 32'(LOST_COUNT), 32'd3);
        chk32("full_words", WORD_COUNT, 32'd17);
        chk32("full_fill", 32'(FILL_LEVEL), 32'd16);

        // Drain with continuous read
        OUT_READ = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk1 ("drain_valid", OUT_VALID, 1'b1);
            chk32("drain_data", OUT_DATA, exp_q.pop_front());
            step();
            if (i == 0) begin
                chk1("drain_ready_back", ARB_READY_OUT, 1'b1);
            end
        end
        OUT_READ = 1'b0;
        chk1 ("drain_empty", OUT_VALID, 1'b0);
        chk32("drain_fill", 32'(FILL_LEVEL), 32'd0);
        chk1 ("drain_full", FIFO_FULL, 1'b0);

        // Steady write+pop at FILL_LEVEL 5
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        seq = 32'h2000_0000;
        for (int i = 0; i < 6; i++) begin
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = seq;
            exp_q.push_back(seq);
            seq = seq + 32'd1;
            step();
        end
        chk32("steady_fill_pre", 32'(FILL_LEVEL), 32'd5);
        OUT_READ = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ARB_DATA_OUT = seq;
            chk1 ("steady_valid", OUT_VALID, 1'b1);
            chk32("steady_data", OUT_DATA, exp_q.pop_front());
            exp_q.push_back(seq);
            seq = seq + 32'd1;
            step();
            chk32("steady_fill", 32'(FILL_LEVEL), 32'd5);
        end
        OUT_READ = 1'b0;
        chk32("steady_words", WORD_COUNT, 32'd106);

        // CLEAR together with a write on a half-full buffer
        for (int i = 0; i < 3; i++) begin
            ARB_DATA_OUT = seq;
            seq = seq + 32'd1;
            step();
        end
        chk32("half_fill", 32'(FILL_LEVEL), 32'd8);
        ARB_DATA_OUT = 32'hDEAD_BEEF;
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        ARB_WRITE_OUT = 1'b0;
        chk1 ("clr_valid", OUT_VALID, 1'b0);
        chk32("clr_fill", 32'(FILL_LEVEL), 32'd0);
        chk32("clr_words", WORD_COUNT, 32'd0);
        chk32("clr_lost", 32'(LOST_COUNT), 32'd0);
        chk1 ("clr_ready", ARB_READY_OUT, 1'b1);
        repeat (3) step();
        chk1 ("clr_no_output", OUT_VALID, 1'b0);
        chk32("clr_fill_late", 32'(FILL_LEVEL), 32'd0);
        exp_q.delete();

        // Reset pulsed mid-burst, between edges
        for (int i = 0; i < 4; i++) begin
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = 32'h3000_0000 + 32'(i);
            step();
        end
        chk1("burst_valid", OUT_VALID, 1'b1);
        #2;
        BUS_RST = 1'b1;
        #1;
        chk1 ("arst_ready", ARB_READY_OUT, 1'b0);
        chk1 ("arst_valid", OUT_VALID, 1'b0);
        chk32("arst_fill", 32'(FILL_LEVEL), 32'd0);
        chk32("arst_words", WORD_COUNT, 32'd0);
        chk32("arst_data", OUT_DATA, 32'd0);
        ARB_WRITE_OUT = 1'b0;
        step();
        BUS_RST = 1'b0;
        step();
        chk1("arst_ready_back", ARB_READY_OUT, 1'b1);
        ARB_WRITE_OUT = 1'b1;
        ARB_DATA_OUT  = 32'hCAFE_0042;
        step();
        ARB_WRITE_OUT = 1'b0;
        step();
        step();
        chk1 ("post_rst_valid", OUT_VALID, 1'b1);
        chk32("post_rst_data", OUT_DATA, 32'hCAFE_0042);
        chk32("post_rst_words", WORD_COUNT, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
